uart_rx: RTL

Asynchronous serial receiver: the receive half of the UART, pairing with the transmitter path on the same 50 MHz system clock and the same 2-bit baud-rate select. It synchronises the `rx` line, detects a start bit using 16× oversampling, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. It presents each byte with a one-cycle valid strobe, or a framing-error strobe on a bad stop bit.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_rx_os_tick.sv | 45 ++++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-select codes, 16x divisor constants and receiver state encoding.
// The PARITY state is only present when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int CLK_HZ_DEFAULT = 50_000_000;
    localparam int OVERSAMPLE     = 16;
    localparam int DIV_W          = 16;

    localparam logic [1:0] BAUD24  = 2'b00;
    localparam logic [1:0] BAUD48  = 2'b01;
    localparam logic [1:0] BAUD96  = 2'b10;
    localparam logic [1:0] BAUD192 = 2'b11;

    // Round to nearest so that 50 MHz yields 1302 / 651 / 326 / 163.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
    endfunction

    localparam int DIV24  = baud_div(CLK_HZ_DEFAULT, 2400);
    localparam int DIV48  = baud_div(CLK_HZ_DEFAULT, 4800);
    localparam int DIV96  = baud_div(CLK_HZ_DEFAULT, 9600);
    localparam int DIV192 = baud_div(CLK_HZ_DEFAULT, 19200);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

endpackage

// File: rtl/uart_rx_os_tick.sv
// 16x oversample tick generator: counts 0..divisor-1 and pulses tick on the wrap.
module uart_rx_os_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [1:0] baud_rate,
    output logic       tick
);

    localparam logic [DIV_W-1:0] MAX24  = DIV_W'(baud_div(CLK_HZ, 2400) - 1);
    localparam logic [DIV_W-1:0] MAX48  = DIV_W'(baud_div(CLK_HZ, 4800) - 1);
    localparam logic [DIV_W-1:0] MAX96  = DIV_W'(baud_div(CLK_HZ, 9600) - 1);
    localparam logic [DIV_W-1:0] MAX192 = DIV_W'(baud_div(CLK_HZ, 19200) - 1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_max;

    always_comb begin
        cnt_max = MAX24;
        case (baud_rate)
            BAUD24:  cnt_max = MAX24;
            BAUD48:  cnt_max = MAX48;
            BAUD96:  cnt_max = MAX96;
            BAUD192: cnt_max = MAX192;
            default: cnt_max = MAX24;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == cnt_max) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign tick = !clr && (cnt == cnt_max);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, 16x oversampled start detect, 8 data bits LSB-first, stop check.
// Define UART_RX_PARITY_EN for start + 8 data + even parity + stop framing.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] baud_rate,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    rx_state_e  state, state_nx;
    logic       rx_m, rx_s;
    logic [1:0] baud_q, baud_q_nx;
    logic [3:0] s_cnt, s_cnt_nx;
    logic [2:0] b_cnt, b_cnt_nx;
    logic [7:0] shreg, shreg_nx, data_nx;
    logic       dv_nx, fe_nx;
    logic       tick, clr;
`ifdef UART_RX_PARITY_EN
    logic       par_bad, par_bad_nx;
    logic       pe_q, pe_nx;
`endif

    uart_rx_os_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .baud_rate (baud_q),
        .tick      (tick)
    );

    always_comb begin
        state_nx  = state;
        baud_q_nx = baud_q;
        s_cnt_nx  = s_cnt;
        b_cnt_nx  = b_cnt;
        shreg_nx  = shreg;
        data_nx   = data;
        dv_nx     = 1'b0;
        fe_nx     = 1'b0;
        clr       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nx = par_bad;
        pe_nx      = 1'b0;
`endif
        case (state)
            IDLE: begin
                clr      = 1'b1;
                s_cnt_nx = '0;
                if (!rx_s) begin
                    baud_q_nx = baud_rate;
                    state_nx  = START;
                end
            end
            START: if (tick) begin
                if (s_cnt == 4'd7) begin
                    s_cnt_nx = '0;
                    b_cnt_nx = '0;
                    state_nx = rx_s ? IDLE : DATA;
                end else begin
                    s_cnt_nx = s_cnt + 4'd1;
                end
            end
            DATA: if (tick) begin
                if (s_cnt == 4'd15) begin
                    shreg_nx = {rx_s, shreg[7:1]};
                    s_cnt_nx = '0;
                    if (b_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end else begin
                        b_cnt_nx = b_cnt + 3'd1;
                    end
                end else begin
                    s_cnt_nx = s_cnt + 4'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                if (s_cnt == 4'd15) begin
                    par_bad_nx = (rx_s != ^shreg);
                    s_cnt_nx   = '0;
                    state_nx   = STOP;
                end else begin
                    s_cnt_nx = s_cnt + 4'd1;
                end
            end
`endif
            STOP: if (tick) begin
                if (s_cnt == 4'd15) begin
                    data_nx  = shreg;
                    s_cnt_nx = '0;
                    dv_nx    = rx_s;
                    fe_nx    = !rx_s;
                    state_nx = rx_s ? IDLE : BREAK;
`ifdef UART_RX_PARITY_EN
                    pe_nx    = par_bad;
`endif
                end else begin
                    s_cnt_nx = s_cnt + 4'd1;
                end
            end
            // A held-low line stays here so it cannot be taken as a new start bit.
            BREAK: if (rx_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            baud_q     <= BAUD24;
            s_cnt      <= '0;
            b_cnt      <= '0;
            shreg      <= '0;
            data       <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            pe_q       <= 1'b0;
`endif
        end else begin
            rx_m       <= rx;
            rx_s       <= rx_m;
            state      <= state_nx;
            baud_q     <= baud_q_nx;
            s_cnt      <= s_cnt_nx;
            b_cnt      <= b_cnt_nx;
            shreg      <= shreg_nx;
            data       <= data_nx;
            data_valid <= dv_nx;
            frame_err  <= fe_nx;
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_nx;
            pe_q       <= pe_nx;
`endif
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule
